// File: rtl/ksk_bank_ctrl.sv
// Sequencer/arbiter in front of one ksk_bram_bank: shares the single bank address port between
// lane-masked row writes and streamed read bursts, and tags returning rows with valid/last.
module ksk_bank_ctrl #(
  parameter int NUM_LANE   = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 64,
  parameter int NB_PIPE    = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [NUM_LANE-1:0]            wr_mask,
  input  logic [DATA_WIDTH*NUM_LANE-1:0] wr_data,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr,
  input  logic [ADDR_WIDTH:0]            cmd_len,
  input  logic                           rd_stall,
  output logic                           rd_valid,
  output logic                           rd_last,
  output logic [DATA_WIDTH*NUM_LANE-1:0] rd_data,
  output logic                           rd_done,
  output logic                           busy,
  output logic [ADDR_WIDTH-1:0]          bank_addr,
  output logic                           bank_wen,
  output logic                           bank_ren,
  output logic [NUM_LANE-1:0]            bank_wmask,
  output logic [DATA_WIDTH*NUM_LANE-1:0] bank_wdata,
  input  logic [DATA_WIDTH*NUM_LANE-1:0] bank_rdata
);

  typedef enum logic {IDLE, READ} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  zdone_q, zdone_d;
  logic                  bank_last_q;
  logic [NB_PIPE-1:0]    ret_vld_q;
  logic [NB_PIPE-1:0]    ret_last_q;
  logic                  wr_fire;
  logic                  cmd_fire;
  logic                  issue;

  // Readies are forced low while reset is asserted, independent of the registered state.
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign wr_ready  = rst_n && (state_q == IDLE) && !cmd_valid;
  assign wr_fire   = wr_valid && wr_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign issue     = (state_q == READ) && !rd_stall;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    zdone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            zdone_d = 1'b1;
          end else begin
            cur_d   = cmd_addr;
            rem_d   = cmd_len;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (!rd_stall) begin
          cur_d = (cur_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_WIDTH + 1)'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      zdone_q <= zdone_d;
    end
  end

  // Bank control stage: writes only happen in IDLE and reads only in READ, so wen/ren are exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_wen    <= 1'b0;
      bank_ren    <= 1'b0;
      bank_addr   <= '0;
      bank_wmask  <= '0;
      bank_last_q <= 1'b0;
    end else begin
      bank_wen    <= wr_fire;
      bank_ren    <= issue;
      bank_last_q <= issue && (rem_q == (ADDR_WIDTH + 1)'(1));
      if (wr_fire) begin
        bank_addr  <= wr_addr;
        bank_wmask <= wr_mask;
      end else if (issue) begin
        bank_addr  <= cur_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) bank_wdata <= wr_data;
  end

  // Return stage: tags follow the bank's read latency so rd_valid lines up with bank_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_vld_q  <= '0;
      ret_last_q <= '0;
    end else begin
      ret_vld_q[0]  <= bank_ren;
      ret_last_q[0] <= bank_ren && bank_last_q;
      for (int i = 1; i < NB_PIPE; i++) begin
        ret_vld_q[i]  <= ret_vld_q[i-1];
        ret_last_q[i] <= ret_last_q[i-1];
      end
    end
  end

  assign rd_valid = ret_vld_q[NB_PIPE-1];
  assign rd_last  = ret_last_q[NB_PIPE-1];
  assign rd_data  = bank_rdata;
  assign rd_done  = (rd_valid && rd_last) || zdone_q;
  assign busy     = (state_q != IDLE) || bank_ren || (|ret_vld_q) || zdone_q;

endmodule
